gng_coef_poly_eval: RTL and testbench

- Requester side of the coefficient ROM interface: takes a segment index plus fractional offset, drives the ROM `address`/`read_en` pins, and captures Coef2/Coef1/Coef0.
- Evaluates y = C2*x^2 + C1*x + C0 in Horner form through a pipeline with valid/ready handshakes.
- Sits between the uniform-sample splitter and the Box-Muller function units (log/sqrt/cos approximations).

---
 rtl/gng_poly_pkg.sv | 32 +++
 rtl/gng_mul_shift.sv | 24 ++
 rtl/gng_coef_poly_eval.sv | 115 +++++++++++
 tb/tb_gng_coef_poly_eval.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gng_poly_pkg.sv
// Shared widths, derived sizes and output saturation for the coefficient
// polynomial evaluator used in front of the Box-Muller function units.
package gng_poly_pkg;

    localparam int ADDR_W = 7;
    localparam int XB_W   = 11;
    localparam int C2_W   = 18;
    localparam int C1_W   = 18;
    localparam int C0_W   = 21;
    localparam int OUT_W  = 21;

    // First Horner partial sum: one guard bit above the wider coefficient
    localparam int S1_W  = ((C2_W > C1_W) ? C2_W : C1_W) + 1;
    localparam int SUM_W = OUT_W + 1;

    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    // Clamp the final sum into the signed OUT_W range. The value fits when all
    // bits from the OUT_W sign position upward agree.
    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [SUM_W-1:0] sum);
        logic [SUM_W-OUT_W:0] top_bits;
        top_bits = sum[SUM_W-1:OUT_W-1];
        if ((top_bits == '0) || (top_bits == '1))
            sat_out = sum[OUT_W-1:0];
        else if (sum[SUM_W-1])
            sat_out = OUT_MIN;
        else
            sat_out = OUT_MAX;
    endfunction

endpackage

// File: rtl/gng_mul_shift.sv
// Signed coefficient times unsigned fraction, floored back to coefficient
// scale by an arithmetic right shift of XB_W bits. Purely combinational.
module gng_mul_shift #(
    parameter int COEF_W = 18,
    parameter int XB_W   = 11
) (
    input  logic signed [COEF_W-1:0] coef,
    input  logic        [XB_W-1:0]   xb,
    output logic signed [COEF_W-1:0] result
);

    logic signed [COEF_W+XB_W:0] prod;
    logic signed [COEF_W+XB_W:0] shifted;
    logic                        unused_high;

    // Zero-extend the fraction so it is treated as a non-negative operand
    assign prod    = coef * $signed({1'b0, xb});
    assign shifted = prod >>> XB_W;

    // |coef * x| < |coef| for x in [0,1), so the floor always fits COEF_W bits
    assign result      = shifted[COEF_W-1:0];
    assign unused_high = ^shifted[COEF_W+XB_W:COEF_W];

endmodule

// File: rtl/gng_coef_poly_eval.sv
// Coefficient ROM requester and 4-stage Horner evaluator of
// y = C2*x^2 + C1*x + C0 with valid/ready handshakes on both sides.
module gng_coef_poly_eval
    import gng_poly_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_seg,
    input  logic [XB_W-1:0]   in_xb,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd_en,
    input  logic [C2_W-1:0]   rom_coef2,
    input  logic [C1_W-1:0]   rom_coef1,
    input  logic [C0_W-1:0]   rom_coef0,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [15:0]       out_count
);

    logic                     v0_reg, v1_reg, v2_reg, out_valid_reg;
    logic [ADDR_W-1:0]        rom_addr_reg;
    logic [XB_W-1:0]          xb0_reg, xb1_reg;
    logic signed [S1_W-1:0]   s1_reg, t2_reg;
    logic signed [C0_W-1:0]   c0_1_reg, c0_2_reg;
    logic [OUT_W-1:0]         out_data_reg;
    logic [15:0]              out_count_reg;

    logic                     stall;
    logic                     accept;
    logic signed [C2_W-1:0]   t1;
    logic signed [S1_W-1:0]   s1_next;
    logic signed [S1_W-1:0]   t2_next;
    logic signed [SUM_W-1:0]  sum;

    assign stall    = out_valid_reg & ~out_ready;
    assign accept   = in_valid & ~stall;
    assign in_ready = ~stall;

    gng_mul_shift #(.COEF_W(C2_W), .XB_W(XB_W)) u_mul_c2 (
        .coef   ($signed(rom_coef2)),
        .xb     (xb0_reg),
        .result (t1)
    );

    assign s1_next = {{(S1_W-C2_W){t1[C2_W-1]}}, t1}
                   + {{(S1_W-C1_W){rom_coef1[C1_W-1]}}, rom_coef1};

    gng_mul_shift #(.COEF_W(S1_W), .XB_W(XB_W)) u_mul_s1 (
        .coef   (s1_reg),
        .xb     (xb1_reg),
        .result (t2_next)
    );

    assign sum = {{(SUM_W-S1_W){t2_reg[S1_W-1]}}, t2_reg}
               + {{(SUM_W-C0_W){c0_2_reg[C0_W-1]}}, c0_2_reg};

    // The whole pipeline, ROM request included, freezes on stall so the
    // combinational ROM outputs stay valid for the sample parked in S0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v0_reg        <= 1'b0;
            v1_reg        <= 1'b0;
            v2_reg        <= 1'b0;
            out_valid_reg <= 1'b0;
            rom_addr_reg  <= '0;
            xb0_reg       <= '0;
            xb1_reg       <= '0;
            s1_reg        <= '0;
            t2_reg        <= '0;
            c0_1_reg      <= '0;
            c0_2_reg      <= '0;
            out_data_reg  <= '0;
        end else if (!stall) begin
            v0_reg <= accept;
            if (accept) begin
                rom_addr_reg <= in_seg;
                xb0_reg      <= in_xb;
            end

            v1_reg <= v0_reg;
            if (v0_reg) begin
                s1_reg   <= s1_next;
                xb1_reg  <= xb0_reg;
                c0_1_reg <= $signed(rom_coef0);
            end

            v2_reg <= v1_reg;
            if (v1_reg) begin
                t2_reg   <= t2_next;
                c0_2_reg <= c0_1_reg;
            end

            out_valid_reg <= v2_reg;
            if (v2_reg)
                out_data_reg <= sat_out(sum);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            out_count_reg <= '0;
        else if (out_valid_reg && out_ready)
            out_count_reg <= out_count_reg + 16'd1;
    end

    assign rom_addr  = rom_addr_reg;
    assign rom_rd_en = v0_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_count = out_count_reg;

endmodule

// File: tb/tb_gng_coef_poly_eval.sv
// Directed bench for gng_coef_poly_eval: table of isolated samples against a
// small ROM model, then streaming/backpressure, mid-flight reset and count wrap.
module tb_gng_coef_poly_eval;
    import gng_poly_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_seg;
    logic [XB_W-1:0]   in_xb;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rd_en;
    logic [C2_W-1:0]   rom_coef2;
    logic [C1_W-1:0]   rom_coef1;
    logic [C0_W-1:0]   rom_coef0;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [15:0]       out_count;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gng_coef_poly_eval dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_seg    (in_seg),
        .in_xb     (in_xb),
        .rom_addr  (rom_addr),
        .rom_rd_en (rom_rd_en),
        .rom_coef2 (rom_coef2),
        .rom_coef1 (rom_coef1),
        .rom_coef0 (rom_coef0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    // Combinational coefficient ROM model: {C2, C1, C0} per entry
    always_comb begin
        rom_coef2 = '0;
        rom_coef1 = '0;
        rom_coef0 = '0;
        if (rom_rd_en) begin
            case (rom_addr)
                7'd0: begin rom_coef2 = 18'(10);      rom_coef1 = 18'(20);      rom_coef0 = 21'(7);        end
                7'd1: begin rom_coef2 = 18'(-3);      rom_coef1 = 18'(5);       rom_coef0 = 21'(-50);      end
                7'd2: begin rom_coef2 = 18'(0);       rom_coef1 = 18'(131071);  rom_coef0 = 21'(1048575);  end
                7'd3: begin rom_coef2 = 18'(0);       rom_coef1 = 18'(-131072); rom_coef0 = 21'(-1048576); end
                7'd4: begin rom_coef2 = 18'(100);     rom_coef1 = 18'(-200);    rom_coef0 = 21'(12345);    end
                7'd5: begin rom_coef2 = 18'(4);       rom_coef1 = 18'(8);       rom_coef0 = 21'(100);      end
                7'd6: begin rom_coef2 = 18'(0);       rom_coef1 = 18'(0);       rom_coef0 = 21'(-1);       end
                7'd7: begin rom_coef2 = 18'(-131072); rom_coef1 = 18'(131071);  rom_coef0 = 21'(0);        end
                7'd8: begin rom_coef2 = 18'(131071);  rom_coef1 = 18'(-131072); rom_coef0 = 21'(555);      end
                7'd9: begin rom_coef2 = 18'(-4);      rom_coef1 = 18'(0);       rom_coef0 = 21'(0);        end
                default: ;
            endcase
        end
    end

    typedef struct {
        logic [ADDR_W-1:0] seg;
        logic [XB_W-1:0]   xb;
        int                exp;
        string             name;
    } vec_t;

    vec_t vecs[10];
    int   c0_tab[10];

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One isolated sample: accepted at edge 1, result visible after edge 4 only
    task automatic run_one(input logic [ADDR_W-1:0] seg, input logic [XB_W-1:0] xb,
                           input int exp, input string nm);
        @(negedge clk);
        in_valid  = 1'b1;
        in_seg    = seg;
        in_xb     = xb;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({nm, " rom_addr"}, int'(rom_addr), int'(seg));
        check({nm, " rom_rd_en"}, int'(rom_rd_en), 1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int e = 2; e <= 4; e++) begin
            @(posedge clk); #1;
            if (e == 2) check({nm, " rom_rd_en drop"}, int'(rom_rd_en), 0);
            if (e < 4)  check({nm, " early out_valid"}, int'(out_valid), 0);
        end
        check({nm, " out_valid"}, int'(out_valid), 1);
        check({nm, " out_data"}, int'($signed(out_data)), exp);
        $display("vec %s seg=%0d xb=%0d out_data=%0d expected=%0d", nm, seg, xb, $signed(out_data), exp);
        @(posedge clk); #1;
        check({nm, " single result"}, int'(out_valid), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OUT_W-1:0]  got[$];
        logic [ADDR_W-1:0] frz_addr;
        logic              frz_seen;
        int                idx, cyc, stale, nhand;

        vecs[0] = '{7'd5, 11'd1024, 105,      "basic_e5"};
        vecs[1] = '{7'd9, 11'd1024, -1,       "neg_floor_e9"};
        vecs[2] = '{7'd2, 11'd2047, 1048575,  "sat_pos_e2"};
        vecs[3] = '{7'd3, 11'd2047, -1048576, "sat_neg_e3"};
        vecs[4] = '{7'd4, 11'd512,  12301,    "quarter_e4"};
        vecs[5] = '{7'd1, 11'd2047, -49,      "xmax_e1"};
        vecs[6] = '{7'd7, 11'd1,    63,       "xmin_e7"};
        vecs[7] = '{7'd8, 11'd2047, 490,      "bigc2_e8"};
        vecs[8] = '{7'd0, 11'd1024, 19,       "half_e0"};
        vecs[9] = '{7'd6, 11'd100,  -1,       "const_e6"};
        c0_tab  = '{7, -50, 1048575, -1048576, 12345, 100, -1, 0, 555, 0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_seg    = '0;
        in_xb     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", int'(out_valid), 0);
        check("reset rom_rd_en", int'(rom_rd_en), 0);
        check("reset rom_addr", int'(rom_addr), 0);
        check("reset out_data", int'(out_data), 0);
        check("reset out_count", int'(out_count), 0);
        check("reset in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_one(vecs[i].seg, vecs[i].xb, vecs[i].exp, vecs[i].name);
        check("table out_count", int'(out_count), 10);

        // Streaming with a 3-cycle out_ready drop in the middle
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        idx = 0; cyc = 0; frz_seen = 1'b0; frz_addr = '0;
        while (got.size() < 10 && cyc < 200) begin
            @(negedge clk);
            out_ready = !(cyc >= 5 && cyc < 8);
            in_valid  = (idx < 10);
            in_seg    = ADDR_W'(idx);
            in_xb     = '0;
            #1;
            if (out_valid && !out_ready) begin
                check("stall in_ready", int'(in_ready), 0);
                check("stall rom_rd_en", int'(rom_rd_en), 1);
                if (!frz_seen) begin
                    frz_addr = rom_addr;
                    frz_seen = 1'b1;
                end else begin
                    check("stall rom_addr frozen", int'(rom_addr), int'(frz_addr));
                end
            end
            if (out_valid && out_ready) got.push_back(out_data);
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream stall seen", int'(frz_seen), 1);
        check("stream result count", got.size(), 10);
        for (int i = 0; i < got.size() && i < 10; i++) begin
            check($sformatf("stream out_data[%0d]", i), int'($signed(got[i])), c0_tab[i]);
            $display("stream %0d out_data=%0d expected=%0d", i, $signed(got[i]), c0_tab[i]);
        end
        repeat (3) @(posedge clk);
        #1;
        check("stream out_count", int'(out_count), 10);
        check("stream no extra result", int'(out_valid), 0);

        // Reset with three samples in flight
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_seg   = ADDR_W'(5 + k);
            in_xb    = 11'd1024;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        check("midreset out_valid", int'(out_valid), 0);
        check("midreset out_count", int'(out_count), 0);
        check("midreset rom_rd_en", int'(rom_rd_en), 0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            if (out_valid) stale++;
        end
        check("midreset stale results", stale, 0);
        check("midreset count held", int'(out_count), 0);

        // Counter wrap: 65537 handoffs at full throughput
        @(negedge clk);
        in_valid = 1'b1;
        in_seg   = 7'd5;
        in_xb    = 11'd1024;
        nhand = 0; cyc = 0;
        while (nhand < 65537 && cyc < 70000) begin
            @(negedge clk); #1;
            if (out_valid && out_ready) nhand++;
            cyc++;
        end
        in_valid = 1'b0;
        check("wrap handoffs", nhand, 65537);
        check("wrap out_data", int'($signed(out_data)), 105);
        @(posedge clk); #1;
        check("wrap out_count", int'(out_count), 1);
        $display("wrap handoffs=%0d out_count=%0d", nhand, out_count);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
